// File: rtl/apple2_paddle_timer.sv
// Multi-channel Apple II paddle (558-style) one-shot timer. Each strobe loads a
// per-channel countdown derived from a signed joystick position, counted in CLK_2M ticks.
module apple2_paddle_timer #(
  parameter int                NUM_CH      = 4,
  parameter int                CNT_W       = 13,
  parameter int                CENTER      = 2800,
  parameter int                GAIN        = 22,
  parameter int                CLAMP_HI    = 5590,
  parameter int                MAX_CNT     = 5650,
  parameter logic [NUM_CH-1:0] INVERT_MASK = '0
) (
  input  logic                CLK_14M,
  input  logic                reset,
  input  logic                CLK_2M,
  input  logic                pdl_strobe,
  input  logic [NUM_CH*8-1:0] pdl_an,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [NUM_CH-1:0]   pdl_out,
  output logic                busy
);

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  logic              clk2m_d_reg;
  logic              strobe_pending_reg;
  logic              tick;
  logic              eff_strobe;
  logic [NUM_CH-1:0] pdl_out_reg;
  logic [NUM_CH-1:0] pdl_out_next;
  logic              busy_reg;

  assign tick       = CLK_2M & ~clk2m_d_reg;
  // A strobe arriving in the same cycle as a tick is consumed by that tick.
  assign eff_strobe = strobe_pending_reg | pdl_strobe;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [31:0] pos;
      logic signed [31:0] raw;
      logic [CNT_W-1:0]   load_val;
      logic [CNT_W-1:0]   cnt_reg;
      logic [CNT_W-1:0]   cnt_next;
      logic               out_next;
      ch_state_t          state;

      // Inversion uses -1-p so the asymmetric range maps -128 onto +127.
      always_comb begin
        pos = {{24{pdl_an[8*gi+7]}}, pdl_an[8*gi +: 8]};
        if (INVERT_MASK[gi]) begin
          pos = -32'sd1 - pos;
        end
        raw = CENTER + GAIN * pos;
        if (raw < 0) begin
          load_val = '0;
        end else if (raw >= CLAMP_HI) begin
          load_val = MAX_V;
        end else begin
          load_val = raw[CNT_W-1:0];
        end
      end

      assign state = (cnt_reg != '0) ? CH_RUN : CH_IDLE;

      always_comb begin
        cnt_next = cnt_reg;
        out_next = pdl_out_reg[gi];
        if (tick) begin
          out_next = (state == CH_RUN) & ch_en[gi];
          if (!ch_en[gi]) begin
            cnt_next = '0;
          end else if (eff_strobe) begin
            cnt_next = load_val;
          end else if (state == CH_RUN) begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end

      assign pdl_out_next[gi] = out_next;

      always_ff @(posedge CLK_14M) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      clk2m_d_reg        <= 1'b0;
      strobe_pending_reg <= 1'b0;
      pdl_out_reg        <= '0;
      busy_reg           <= 1'b0;
    end else begin
      clk2m_d_reg        <= CLK_2M;
      strobe_pending_reg <= tick ? 1'b0 : (strobe_pending_reg | pdl_strobe);
      pdl_out_reg        <= pdl_out_next;
      busy_reg           <= |pdl_out_next;
    end
  end

  assign pdl_out = pdl_out_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_apple2_paddle_timer.sv
// Directed bench for apple2_paddle_timer: a plain instance and one with ch0 inverted
// share all inputs. CLK_2M toggles every CLK_14M negedge, so one tick = 2 cycles.
module tb_apple2_paddle_timer;

  logic        CLK_14M = 1'b0;
  logic        reset = 1'b1;
  logic        CLK_2M = 1'b0;
  logic        clk2m_hold = 1'b0;
  logic        pdl_strobe = 1'b0;
  logic [31:0] pdl_an = '0;
  logic [3:0]  ch_en = 4'hF;
  logic [3:0]  pdl_out_a, pdl_out_b;
  logic        busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;
  int hi_a [4] = '{0, 0, 0, 0};
  int hi_b [4] = '{0, 0, 0, 0};
  int s_a  [4];
  int s_b  [4];

  apple2_paddle_timer dut_a (
    .CLK_14M(CLK_14M), .reset(reset), .CLK_2M(CLK_2M), .pdl_strobe(pdl_strobe),
    .pdl_an(pdl_an), .ch_en(ch_en), .pdl_out(pdl_out_a), .busy(busy_a)
  );

  apple2_paddle_timer #(.INVERT_MASK(4'b0001)) dut_b (
    .CLK_14M(CLK_14M), .reset(reset), .CLK_2M(CLK_2M), .pdl_strobe(pdl_strobe),
    .pdl_an(pdl_an), .ch_en(ch_en), .pdl_out(pdl_out_b), .busy(busy_b)
  );

  always #5 CLK_14M = ~CLK_14M;

  always @(negedge CLK_14M) begin
    if (!clk2m_hold) CLK_2M = ~CLK_2M;
  end

  // Cumulative count of cycles each output is high.
  always @(negedge CLK_14M) begin
    for (int k = 0; k < 4; k++) begin
      if (pdl_out_a[k]) hi_a[k]++;
      if (pdl_out_b[k]) hi_b[k]++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK_14M);
      #1;
    end
  endtask

  // Wait until the upcoming posedge has CLK_2M == want (0: non-tick, 1: tick).
  task automatic align(input logic want);
    int n;
    n = 0;
    while (CLK_2M !== want && n < 4) begin
      step(1);
      n++;
    end
    if (n == 4) check("align_timeout", 0, 1);
  endtask

  task automatic snap();
    s_a = hi_a;
    s_b = hi_b;
  endtask

  // One-cycle strobe in a non-tick cycle; returns just after the loading tick.
  task automatic fire();
    align(1'b0);
    pdl_strobe = 1'b1;
    step(1);
    pdl_strobe = 1'b0;
    step(1);
  endtask

  initial begin
    // Reset with CLK_2M toggling and strobe pulsing.
    step(1);
    for (int i = 0; i < 6; i++) begin
      pdl_strobe = i[0];
      step(1);
      check("rst_out", int'(pdl_out_a), 0);
      check("rst_busy", int'(busy_a), 0);
    end
    pdl_strobe = 1'b0;
    reset = 1'b0;
    snap();
    step(20);
    check("post_rst_out", int'(pdl_out_a), 0);
    check("post_rst_hi", hi_a[0] + hi_a[1] + hi_a[2] + hi_a[3] - s_a[0] - s_a[1] - s_a[2] - s_a[3], 0);

    // Center / clamps in parallel: ch0=0, ch1=+127, ch2=+126, ch3=-128.
    pdl_an = {8'h80, 8'h7E, 8'h7F, 8'h00};
    snap();
    fire();
    check("ctr_latch", int'(pdl_out_a[0]), 0);
    step(2);
    check("ctr_rise", int'(pdl_out_a[0]), 1);
    check("ctr_busy", int'(busy_a), 1);
    step(2 * 5650 + 20);
    check("ctr_len", hi_a[0] - s_a[0], 2 * 2800);
    check("clamp_hi_len", hi_a[1] - s_a[1], 2 * 5650);
    check("near_hi_len", hi_a[2] - s_a[2], 2 * 5572);
    check("clamp_lo_len", hi_a[3] - s_a[3], 0);
    check("inv_zero_len", hi_b[0] - s_b[0], 2 * 2778);
    check("idle_busy", int'(busy_a), 0);

    // Invert on ch0=-128; ch3 disabled; ch2 disabled mid-pulse.
    pdl_an = {8'h00, 8'h00, 8'h00, 8'h80};
    ch_en = 4'b0111;
    snap();
    fire();
    step(2);
    check("en_rise", int'(pdl_out_a[2]), 1);
    step(2 * 499);
    ch_en = 4'b0011;
    step(1);
    check("en_hold", int'(pdl_out_a[2]), 1);
    step(1);
    check("en_drop", int'(pdl_out_a[2]), 0);
    step(2 * 5650 + 20);
    check("inv_neg_len", hi_b[0] - s_b[0], 2 * 5650);
    check("noinv_neg_len", hi_a[0] - s_a[0], 0);
    check("ch1_len", hi_a[1] - s_a[1], 2 * 2800);
    check("ch2_cut_len", hi_a[2] - s_a[2], 2 * 500);
    check("ch3_dis_len", hi_a[3] - s_a[3], 0);
    check("inv_busy_idle", int'(busy_b), 0);
    ch_en = 4'hF;

    // Retrigger: strobe consumed at the 1000th high tick.
    pdl_an = 32'h0000_0000;
    snap();
    fire();
    step(2);
    step(2 * 998);
    pdl_strobe = 1'b1;
    step(1);
    pdl_strobe = 1'b0;
    step(1);
    check("retrig_high", int'(pdl_out_a[0]), 1);
    step(2 * 2800 + 20);
    check("retrig_len", hi_a[0] - s_a[0], 2 * 3800);
    check("retrig_inv_len", hi_b[0] - s_b[0], 2 * 3778);

    // Strobe coincident with a tick, ch0=-80 -> 1040.
    pdl_an = {8'h80, 8'h80, 8'h80, 8'hB0};
    snap();
    align(1'b1);
    pdl_strobe = 1'b1;
    step(1);
    pdl_strobe = 1'b0;
    check("coin_latch", int'(pdl_out_a[0]), 0);
    step(2);
    check("coin_rise", int'(pdl_out_a[0]), 1);
    step(2 * 1040 + 20);
    check("coin_len", hi_a[0] - s_a[0], 2 * 1040);

    // Two strobes with CLK_2M held low; load uses pdl_an at the tick (-64 -> 1392).
    snap();
    align(1'b0);
    clk2m_hold = 1'b1;
    pdl_strobe = 1'b1;
    step(1);
    pdl_strobe = 1'b0;
    step(2);
    pdl_strobe = 1'b1;
    step(1);
    pdl_strobe = 1'b0;
    step(3);
    check("hold_no_out", int'(pdl_out_a[0]), 0);
    pdl_an = {8'h80, 8'h80, 8'h80, 8'hC0};
    clk2m_hold = 1'b0;
    step(2 * 1392 + 20);
    check("dbl_len", hi_a[0] - s_a[0], 2 * 1392);

    // Reset in mid-pulse, then a full pulse after release.
    pdl_an = {8'h80, 8'h80, 8'h80, 8'hB0};
    fire();
    step(2 + 200);
    check("mid_running", int'(pdl_out_a[0]), 1);
    reset = 1'b1;
    step(1);
    check("mid_rst_out", int'(pdl_out_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_out_b", int'(pdl_out_b), 0);
    reset = 1'b0;
    step(4);
    check("mid_after", int'(pdl_out_a), 0);
    snap();
    fire();
    step(2);
    check("mid_rise", int'(pdl_out_a[0]), 1);
    step(2 * 1040 + 20);
    check("mid_len", hi_a[0] - s_a[0], 2 * 1040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
